lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first:
  i_clk  in  1  single clock; all state updates on its rising edge
  i_rst  in  1  synchronous, active-high reset
  i_req_valid  in  1  core presents a load/store request
  o_req_ready  out  1  block accepts a request this cycle
  i_addr  in  32  effective byte address (ALU result)
  i_wdata  in  32  store data (rs2)
  i_is_store  in  1  1 = store, 0 = load
  i_funct3  in  3  RV32I width/sign code (LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2)
  o_rsp_valid  out  1  one-cycle completion pulse
  o_rdata  out  32  load result, extended per funct3
  o_fault  out  1  access failed; valid with o_rsp_valid
  o_mem_req  out  1  memory request, held until acknowledged
  o_mem_we  out  1  memory write enable
  o_mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
  o_mem_wdata  out  32  store data replicated into byte lanes
  o_mem_be  out  4  byte enables
  i_mem_ack  in  1  memory accepted/completed the request
  i_mem_rdata  in  32  read word, valid when i_mem_ack=1

Function
REQ-002 The FSM SHALL have states IDLE, MEM, RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-003 Handshake: a request is accepted when i_req_valid & o_req_ready; addr, wdata, is_store and funct3 SHALL be registered on acceptance.
REQ-004 Fault check at acceptance: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, load funct3 in {3,6,7}, or store funct3>2 SHALL mark a fault.
REQ-005 A faulting request SHALL go IDLE->RESP without asserting o_mem_req; in RESP, o_fault=1 and o_rdata=0.
REQ-006 A non-faulting request SHALL go IDLE->MEM; in MEM, o_mem_req=1 and addr/we/be/wdata SHALL be held stable until the i_mem_ack cycle.
REQ-007 On i_mem_ack in MEM, i_mem_rdata SHALL be captured and the FSM SHALL go to RESP; i_mem_ack outside MEM SHALL be ignored.
REQ-008 RESP SHALL last exactly one cycle with o_rsp_valid=1, then return to IDLE; minimum accept-to-rsp latency is 2 cycles (zero-wait ack) and 1 cycle for a fault.
REQ-009 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads SHALL drive the same be pattern with o_mem_we=0.
REQ-010 Store data: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata.
REQ-011 Load data: select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-012 o_rdata SHALL be 0 for stores and whenever o_rsp_valid=0.

Reset
REQ-013 With i_rst=1 at a rising edge, the FSM SHALL enter IDLE, from any state including MEM.
REQ-014 From the cycle after reset: o_req_ready=1; o_rsp_valid, o_fault, o_mem_req and o_mem_we=0; o_mem_addr, o_mem_wdata, o_rdata=0; o_mem_be=4'b0000.
REQ-015 A request aborted in MEM by reset SHALL produce no response, and the i_mem_ack for it SHALL be ignored.

Configuration
REQ-016 Macro LSU_TIMEOUT_EN: when defined, a 4-bit counter SHALL clear on entry to MEM and increment each MEM cycle without ack.
REQ-017 With LSU_TIMEOUT_EN, after 16 MEM cycles without ack, o_mem_req SHALL drop and the FSM SHALL go to RESP with o_fault=1 and o_rdata=0; an ack in the 16th cycle wins.
REQ-018 Without LSU_TIMEOUT_EN, the FSM SHALL wait in MEM indefinitely and SHALL contain no counter.

Verification
REQ-019 SW at addr 0x100, wdata 0xDEADBEEF, ack after 0 waits -> mem_addr 0x100, be 1111, we=1; rsp_valid 2 cycles after accept, fault=0.
REQ-020 LB at 0x203, i_mem_rdata 0x80FF_FF7F -> be 1000; rdata 0xFFFFFF80. LBU same -> rdata 0x00000080.
REQ-021 SH at 0x302, wdata 0x0000ABCD -> wdata 0xABCDABCD, be 1100. LH at 0x301 -> no mem_req; rsp_valid next cycle with fault=1.
REQ-022 LW at 0x40, ack delayed 3 cycles -> mem_req held 4 cycles with stable address; o_req_ready=0 throughout; rsp_valid once.
REQ-023 i_rst pulse in MEM cycle 2, then late ack -> no rsp_valid; idle outputs per REQ-014.
REQ-024 With LSU_TIMEOUT_EN and no ack -> mem_req drops after 16 cycles; rsp_valid with fault=1. Without it -> mem_req still high after 100 cycles.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding request, IDLE -> MEM -> RESP handshake FSM.
// Optional macro LSU_TIMEOUT_EN adds a 16-cycle memory acknowledge timeout that faults the access.
module lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t     state;
  logic [1:0] addr_lo;
  logic [2:0] funct3;
  logic       is_store;
`ifdef LSU_TIMEOUT_EN
  logic [3:0] wait_cnt;
`endif

  function automatic logic is_fault(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic f;
    if (st) begin
      f = (f3 > 3'd2) || (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a != 2'b00);
    end else begin
      case (f3)
        3'd0, 3'd4: f = 1'b0;
        3'd1, 3'd5: f = a[0];
        3'd2:       f = (a != 2'b00);
        default:    f = 1'b1;
      endcase
    end
    return f;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Lane select by the low address bits, then sign/zero extend by funct3.
  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] d;
    sh = rd >> {a, 3'b000};
    case (f3)
      3'd0:    d = {{24{sh[7]}}, sh[7:0]};
      3'd1:    d = {{16{sh[15]}}, sh[15:0]};
      3'd4:    d = {24'd0, sh[7:0]};
      3'd5:    d = {16'd0, sh[15:0]};
      default: d = rd;
    endcase
    return d;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rdata     <= 32'd0;
      o_fault     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 32'd0;
      o_mem_be    <= 4'b0000;
      addr_lo     <= 2'b00;
      funct3      <= 3'd0;
      is_store    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt    <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            addr_lo     <= i_addr[1:0];
            funct3      <= i_funct3;
            is_store    <= i_is_store;
            o_req_ready <= 1'b0;
            if (is_fault(i_is_store, i_funct3, i_addr[1:0])) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_fault     <= 1'b1;
              o_rdata     <= 32'd0;
            end else begin
              state       <= MEM;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_is_store;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_be    <= byte_en(i_funct3, i_addr[1:0]);
              o_mem_wdata <= store_data(i_funct3, i_wdata);
`ifdef LSU_TIMEOUT_EN
              wait_cnt    <= 4'd0;
`endif
            end
          end
        end
        MEM: begin
          if (i_mem_ack) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_fault     <= 1'b0;
            o_rdata     <= is_store ? 32'd0 : load_data(funct3, addr_lo, i_mem_rdata);
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_be    <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
          end else if (wait_cnt == 4'd15) begin
            // Sixteenth unacknowledged cycle: abandon the access as a fault.
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_fault     <= 1'b1;
            o_rdata     <= 32'd0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_be    <= 4'b0000;
          end else begin
            wait_cnt    <= wait_cnt + 4'd1;
`endif
          end
        end
        RESP: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_fault     <= 1'b0;
          o_rdata     <= 32'd0;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_addr(addr), .i_wdata(wdata), .i_is_store(is_store), .i_funct3(funct3),
    .o_rsp_valid(rsp_valid), .o_rdata(rdata), .o_fault(fault),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 fault=%b rdata=%h expected no response",
                 fault, rdata);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_fault", {31'd0, fault}, {31'd0, e.fault});
        chk("rsp_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
  endtask

  // Present one request at a negedge; accepted at the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic st,
                       input logic [2:0] f3);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    addr      = a;
    wdata     = wd;
    is_store  = st;
    funct3    = f3;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic st, input logic [2:0] f3, input logic [31:0] mrd,
                        input int waits, input logic efault, input logic [31:0] erd,
                        input logic [3:0] ebe, input logic [31:0] ewd);
    rsp_t e;
    e.fault = efault;
    e.rdata = erd;
    sb.push_back(e);
    issue(a, wd, st, f3);
    if (efault) begin
      chk({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_fault_latency"}, {31'd0, rsp_valid}, 32'd1);
    end else begin
      for (int i = 0; i <= waits; i++) begin
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, ebe});
        chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, st});
        if (st) chk({tag, "_mem_wdata"}, mem_wdata, ewd);
        chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_no_early_rsp"}, {31'd0, rsp_valid}, 32'd0);
        if (i == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = mrd;
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
      end
      chk({tag, "_rsp_latency"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_mem_req_drop"}, {31'd0, mem_req}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_rsp_once"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_back_idle"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rdata_idle"}, rdata, 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    do_req("sw", 32'h100, 32'hDEADBEEF, 1'b1, 3'd2, 32'h0, 0, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
    do_req("lb", 32'h203, 32'h0, 1'b0, 3'd0, 32'h80FFFF7F, 0, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0);
    do_req("lbu", 32'h203, 32'h0, 1'b0, 3'd4, 32'h80FFFF7F, 1, 1'b0, 32'h00000080, 4'b1000, 32'h0);
    do_req("lb0", 32'h200, 32'h0, 1'b0, 3'd0, 32'h80FFFF7F, 0, 1'b0, 32'h0000007F, 4'b0001, 32'h0);
    do_req("lh", 32'h202, 32'h0, 1'b0, 3'd1, 32'h80FFFF7F, 0, 1'b0, 32'hFFFF80FF, 4'b1100, 32'h0);
    do_req("lhu", 32'h202, 32'h0, 1'b0, 3'd5, 32'h80FFFF7F, 0, 1'b0, 32'h000080FF, 4'b1100, 32'h0);
    do_req("sh", 32'h302, 32'h0000ABCD, 1'b1, 3'd1, 32'h0, 0, 1'b0, 32'h0, 4'b1100, 32'hABCDABCD);
    do_req("sb", 32'h101, 32'h123456AB, 1'b1, 3'd0, 32'hFFFFFFFF, 2, 1'b0, 32'h0, 4'b0010, 32'hABABABAB);
    do_req("lh_mis", 32'h301, 32'h0, 1'b0, 3'd1, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req("lw_mis", 32'h41, 32'h0, 1'b0, 3'd2, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req("sw_mis", 32'h102, 32'h1, 1'b1, 3'd2, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req("ld_f3", 32'h0, 32'h0, 1'b0, 3'd3, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req("st_f3", 32'h0, 32'h0, 1'b1, 3'd4, 32'h0, 0, 1'b1, 32'h0, 4'b0000, 32'h0);
    do_req("lw", 32'h40, 32'h0, 1'b0, 3'd2, 32'h12345678, 3, 1'b0, 32'h12345678, 4'b1111, 32'h0);

    // Stray ack while idle must not produce anything.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ack_ready", {31'd0, req_ready}, 32'd1);

    // Reset during the second MEM cycle, then a late ack.
    issue(32'h500, 32'h0, 1'b0, 3'd2);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    mem_ack   = 1'b1;
    mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ack_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_idle("late_ack");

`ifdef LSU_TIMEOUT_EN
    begin
      rsp_t e;
      e.fault = 1'b1;
      e.rdata = 32'd0;
      sb.push_back(e);
    end
    issue(32'h600, 32'h0, 1'b0, 3'd2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n, 32'd16);
    chk("timeout_rsp", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("timeout_idle", {31'd0, req_ready}, 32'd1);
`else
    issue(32'h600, 32'h0, 1'b0, 3'd2);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem_req === 1'b1) n++;
      @(negedge clk);
    end
    chk("no_timeout_hold", n, 32'd100);
    chk("no_timeout_still_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("post_hold");
`endif

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
